// File: rtl/dcache_wb_buffer.sv
// Data-cache write-back buffer: holds one dirty victim line and streams it to memory.
// Optional macro WB_FORWARD_EN adds forwarding of buffered words on a query hit.
module dcache_wb_buffer #(
   parameter int LINE_WORDS = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     evict_valid,
   input  logic                     evict_dirty,
   input  logic [ADDR_WIDTH-1:0]    evict_addr,
   input  logic [LINE_WORDS*32-1:0] evict_data,
   output logic                     evict_ready,
   output logic                     wr_addr_valid,
   input  logic                     wr_addr_ready,
   output logic [ADDR_WIDTH-1:0]    wr_addr,
   output logic                     wr_data_valid,
   input  logic                     wr_data_ready,
   output logic [31:0]              wr_data,
   output logic                     wr_last,
   input  logic                     wr_resp_valid,
   input  logic [ADDR_WIDTH-1:0]    query_addr,
   output logic                     query_hit,
   output logic [31:0]              query_data,
   output logic                     busy
);
   localparam int BEAT_W   = $clog2(LINE_WORDS);
   localparam int OFF_BITS = BEAT_W + 2;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t                   state_r;
   state_t                   state_next_s;
   logic [BEAT_W-1:0]        beat_r;
   logic [ADDR_WIDTH-1:0]    addr_r;
   logic [LINE_WORDS*32-1:0] data_r;
   logic [31:0]              words_s [LINE_WORDS];
   logic                     accept_s;
   logic                     line_match_s;
   logic                     unused_query_s;

   assign accept_s = (state_r == IDLE) && evict_valid && evict_dirty;

   for (genvar w = 0; w < LINE_WORDS; w++) begin : g_word
      assign words_s[w] = data_r[32*w +: 32];
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; clean victims are consumed in IDLE without leaving it
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: if (evict_valid && evict_dirty) state_next_s = ADDR; else state_next_s = IDLE;
         ADDR: if (wr_addr_ready) state_next_s = DATA; else state_next_s = ADDR;
         DATA: if (wr_data_ready && (beat_r == LAST_BEAT)) state_next_s = RESP; else state_next_s = DATA;
         RESP: if (wr_resp_valid) state_next_s = IDLE; else state_next_s = RESP;
         default: state_next_s = IDLE;
      endcase
   end

   // Victim capture and beat counter; the counter saturates on the last beat
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_r <= '0;
         addr_r <= '0;
         data_r <= '0;
      end else begin
         if (accept_s) begin
            addr_r <= evict_addr;
            data_r <= evict_data;
         end
         if ((state_r == ADDR) && wr_addr_ready) begin
            beat_r <= '0;
         end else if ((state_r == DATA) && wr_data_ready && (beat_r != LAST_BEAT)) begin
            beat_r <= beat_r + 1'b1;
         end
      end
   end

   // Output decode; everything but evict_ready is forced low while reset is held
   always_comb begin
      evict_ready   = 1'b0;
      wr_addr_valid = 1'b0;
      wr_data_valid = 1'b0;
      wr_last       = 1'b0;
      busy          = 1'b0;
      case (state_r)
         IDLE: evict_ready = 1'b1;
         ADDR: begin
            wr_addr_valid = !reset;
            busy          = !reset;
         end
         DATA: begin
            wr_data_valid = !reset;
            wr_last       = !reset && (beat_r == LAST_BEAT);
            busy          = !reset;
         end
         RESP: busy = !reset;
         default: evict_ready = 1'b0;
      endcase
   end

   assign wr_addr      = addr_r;
   assign wr_data      = words_s[beat_r];
   assign line_match_s = (query_addr[ADDR_WIDTH-1:OFF_BITS] == addr_r[ADDR_WIDTH-1:OFF_BITS]);
   assign query_hit    = busy && line_match_s;

`ifdef WB_FORWARD_EN
   logic [BEAT_W-1:0] query_word_s;
   assign query_word_s   = query_addr[OFF_BITS-1:2];
   assign query_data     = query_hit ? words_s[query_word_s] : 32'd0;
   assign unused_query_s = ^query_addr[1:0];
`else
   assign query_data     = 32'd0;
   assign unused_query_s = ^query_addr[OFF_BITS-1:0];
`endif

endmodule
